program_fetch_unit: RTL

Downstream neighbour of the next-program identifier stage in Processor K1. Latches the next program number into the program counter and fetches the instruction at that address from instruction memory over a req/ack handshake. Presents the instruction to decode with a valid/ready handshake. Feeds the current count back to the identifier stage for the +1 path.

---
 rtl/k1_pkg.sv | 15 +
 rtl/program_fetch_unit_if.sv | 38 +++
 rtl/fetch_timeout_counter.sv | 33 +++
 rtl/program_fetch_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/k1_pkg.sv
// k1_pkg: shared types and default widths for the Processor K1 front end.
// Optional feature macro used by the fetch unit: FETCH_TIMEOUT_EN.
package k1_pkg;

    localparam int K1_SIZE        = 8;
    localparam int K1_INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_FETCH     = 2'd1,
        S_HOLD      = 2'd2,
        S_WAIT_NEXT = 2'd3
    } fetchState_t;

endpackage

// File: rtl/program_fetch_unit_if.sv
// program_fetch_unit_if: instruction-memory req/ack bus plus the
// instruction valid/ready link to decode. The master side is the fetch unit.
interface program_fetch_unit_if
    import k1_pkg::*;
#(
    parameter int SIZE        = K1_SIZE,
    parameter int INSTR_WIDTH = K1_INSTR_WIDTH
);

    logic                   imemReq;
    logic [SIZE-1:0]        imemAddr;
    logic                   imemAck;
    logic [INSTR_WIDTH-1:0] imemData;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instrValid;
    logic                   instrReady;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemData,
        output instr,
        output instrValid,
        input  instrReady
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemData,
        input  instr,
        input  instrValid,
        output instrReady
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts cycles a fetch has waited for its ack and
// flags expiry on the TIMEOUT-th waiting cycle. Present only when the
// FETCH_TIMEOUT_EN macro is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count;

    assign expired = enable && (count == CntW'(TIMEOUT - 1));

    // Wait counter: restarts on clear or on expiry, otherwise advances while enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CntW'(1);
        end
    end

endmodule
`endif

// File: rtl/program_fetch_unit.sv
// program_fetch_unit: latches the next program number into the PC, fetches
// the instruction at that address over req/ack and hands it to decode over
// valid/ready. currentCount feeds the PC back to the identifier stage.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch retry on missing ack,
// reported through the sticky fetchError flag).
module program_fetch_unit
    import k1_pkg::*;
#(
    parameter int              SIZE        = K1_SIZE,
    parameter int              INSTR_WIDTH = K1_INSTR_WIDTH,
    parameter logic [SIZE-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SIZE-1:0]       nextProgramNum,
    input  logic                  nextProgramValid,
    output logic [SIZE-1:0]       currentCount,
    program_fetch_unit_if.master  bus,
    output logic                  protocolError,
    output logic                  fetchError
);

    if (TIMEOUT < 2) begin : gTimeoutRange
        $error("program_fetch_unit: TIMEOUT must be at least 2");
    end

    fetchState_t            state;
    logic [SIZE-1:0]        pc;
    logic [SIZE-1:0]        pendingPc;
    logic                   pending;
    logic                   imemReqQ;
    logic [INSTR_WIDTH-1:0] instrQ;
    logic                   instrValidQ;
    logic                   protocolErrorQ;
    logic                   handshake;
    logic                   stashNext;

    assign currentCount   = pc;
    assign bus.imemAddr   = pc;
    assign bus.imemReq    = imemReqQ;
    assign bus.instr      = instrQ;
    assign bus.instrValid = instrValidQ;
    assign protocolError  = protocolErrorQ;

    assign handshake = instrValidQ && bus.instrReady;
    assign stashNext = (state == S_HOLD) && !handshake && nextProgramValid;

`ifdef FETCH_TIMEOUT_EN
    logic fetchErrorQ;
    logic waitClear;
    logic waitEnable;
    logic expired;

    // The counter runs only while a request is actually outstanding; the
    // one-cycle request drop after expiry and every other state hold it at 0.
    assign waitClear  = !((state == S_FETCH) && imemReqQ);
    assign waitEnable = (state == S_FETCH) && imemReqQ && !bus.imemAck;
    assign fetchError = fetchErrorQ;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) uTimeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (waitClear),
        .enable  (waitEnable),
        .expired (expired)
    );
`else
    assign fetchError = 1'b0;
`endif

    // Address of a next-program strobe that arrived while decode was stalled.
    always_ff @(posedge clk) begin
        if (stashNext) begin
            pendingPc <= nextProgramNum;
        end
    end

    // Fetch sequencer: PC, memory request, decode output and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_BOOT;
            pc             <= RESET_PC;
            pending        <= 1'b0;
            imemReqQ       <= 1'b0;
            instrQ         <= '0;
            instrValidQ    <= 1'b0;
            protocolErrorQ <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetchErrorQ    <= 1'b0;
`endif
        end else begin
            case (state)
                S_BOOT: begin
                    if (nextProgramValid) begin
                        protocolErrorQ <= 1'b1;
                    end
                    imemReqQ <= 1'b1;
                    state    <= S_FETCH;
                end

                S_FETCH: begin
                    if (nextProgramValid) begin
                        protocolErrorQ <= 1'b1;
                    end
                    if (imemReqQ && bus.imemAck) begin
                        instrQ      <= bus.imemData;
                        instrValidQ <= 1'b1;
                        imemReqQ    <= 1'b0;
                        state       <= S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (expired) begin
                        fetchErrorQ <= 1'b1;
                        imemReqQ    <= 1'b0;
                    end else if (!imemReqQ) begin
                        imemReqQ <= 1'b1;
                    end
`endif
                end

                S_HOLD: begin
                    if (handshake) begin
                        instrValidQ <= 1'b0;
                        if (pending || nextProgramValid) begin
                            // A stashed address wins; a fresh strobe on top
                            // of it cannot be kept and is flagged.
                            pc       <= pending ? pendingPc : nextProgramNum;
                            pending  <= 1'b0;
                            imemReqQ <= 1'b1;
                            state    <= S_FETCH;
                            if (pending && nextProgramValid) begin
                                protocolErrorQ <= 1'b1;
                            end
                        end else begin
                            state <= S_WAIT_NEXT;
                        end
                    end else if (nextProgramValid) begin
                        pending <= 1'b1;
                        if (pending) begin
                            protocolErrorQ <= 1'b1;
                        end
                    end
                end

                S_WAIT_NEXT: begin
                    if (nextProgramValid) begin
                        pc       <= nextProgramNum;
                        imemReqQ <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                default: begin
                    state    <= S_BOOT;
                    imemReqQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
